axis_adc_channel_split: RTL and testbench

- Parametrised AXI-Stream channel splitter for packed multi-channel ADC words.
- Accepts one beat carrying NCH lanes and emits each channel on its own AXI-Stream master, widened to AXIS_TDATA_WIDTH.
- Conversion per channel is selectable: sign-extend, zero-extend, offset-binary-to-two's-complement, or saturating negate.
- Sits between the ADC capture stream and per-channel consumers (averager, DDC, DMA); supports blocking (backpressure) and non-blocking (drop-and-count) input modes.

---
 rtl/axis_adc_channel_split.sv | 117 +++++++++++
 tb/tb_axis_adc_channel_split.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_adc_channel_split.sv
// AXI-Stream splitter: one packed multi-lane ADC beat in, one
// widened and converted stream per channel out.
module axis_adc_channel_split #(
  parameter int NCH              = 2,
  parameter int ADC_DATA_WIDTH   = 14,
  parameter int IN_LANE_WIDTH    = 16,
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NCH*IN_LANE_WIDTH-1:0]  s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [NCH*AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [NCH-1:0]                m_axis_tvalid,
  input  logic [NCH-1:0]                m_axis_tready,
  input  logic [1:0]                    cfg_mode,
  input  logic [NCH-1:0]                cfg_chan_en,
  input  logic                          cfg_nonblock,
  input  logic                          cfg_drop_clr,
  output logic [31:0]                   sts_drop_count
);

  localparam int W  = ADC_DATA_WIDTH;
  localparam int OW = AXIS_TDATA_WIDTH;
  localparam int LW = IN_LANE_WIDTH;

  logic [NCH-1:0]    valid_q;
  logic [NCH*OW-1:0] data_q;
  logic [31:0]       drop_q;
  logic              free;
  logic              en_any;
  logic              load;
  logic              drop;

  function automatic logic [OW-1:0] conv(
    input logic [1:0]   mode,
    input logic [W-1:0] x
  );
    logic [W-1:0] y;
    logic         ext;
    y   = x;
    ext = x[W-1];
    unique case (mode)
      2'd0: begin
        y   = x;
        ext = x[W-1];
      end
      2'd1: begin
        y   = x;
        ext = 1'b0;
      end
      2'd2: begin
        y   = {~x[W-1], x[W-2:0]};
        ext = ~x[W-1];
      end
      2'd3: begin
        // -(-2^(W-1)) is not representable; clamp to max positive
        if (x == {1'b1, {(W-1){1'b0}}})
          y = {1'b0, {(W-1){1'b1}}};
        else
          y = ~x + {{(W-1){1'b0}}, 1'b1};
        ext = y[W-1];
      end
    endcase
    return {{(OW-W){ext}}, y};
  endfunction

  always_comb begin
    free = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (valid_q[i] && !m_axis_tready[i])
        free = 1'b0;
    end
  end

  assign en_any        = |cfg_chan_en;
  assign s_axis_tready = cfg_nonblock | free | ~en_any;
  assign load          = s_axis_tvalid & free;
  assign drop          = cfg_nonblock & s_axis_tvalid
                       & ~free & en_any;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load) begin
          if (cfg_chan_en[i]) begin
            data_q[i*OW +: OW] <=
              conv(cfg_mode, s_axis_tdata[i*LW +: W]);
            valid_q[i] <= 1'b1;
          end else begin
            valid_q[i] <= 1'b0;
          end
        end else if (m_axis_tready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      drop_q <= '0;
    else if (cfg_drop_clr)
      drop_q <= '0;
    else if (drop && (drop_q != '1))
      drop_q <= drop_q + 32'd1;
  end

  assign m_axis_tdata   = data_q;
  assign m_axis_tvalid  = valid_q;
  assign sts_drop_count = drop_q;

endmodule

// File: tb/tb_axis_adc_channel_split.sv
// Bench for axis_adc_channel_split: vector table, random
// traffic against a queue model, and hand-written corner cases.
module tb_axis_adc_channel_split;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [1:0]  m_tvalid;
  logic [1:0]  m_tready;
  logic [1:0]  cfg_mode;
  logic [1:0]  cfg_chan_en;
  logic        cfg_nonblock;
  logic        cfg_drop_clr;
  logic [31:0] sts_drop_count;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  longint mcnt = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 aclk = ~aclk;

  axis_adc_channel_split dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .cfg_mode       (cfg_mode),
    .cfg_chan_en    (cfg_chan_en),
    .cfg_nonblock   (cfg_nonblock),
    .cfg_drop_clr   (cfg_drop_clr),
    .sts_drop_count (sts_drop_count)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] l0;
    logic [15:0] l1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: interpret the 14-bit code as a number
  function automatic logic [31:0] ref_conv(input logic [1:0] mode,
                                           input logic [15:0] lane);
    int x;
    int s;
    int r;
    x = int'(lane & 16'h3FFF);
    s = (x >= 8192) ? x - 16384 : x;
    case (mode)
      2'd0: r = s;
      2'd1: r = x;
      2'd2: r = x - 8192;
      default: r = (s == -8192) ? 8191 : -s;
    endcase
    return 32'(r);
  endfunction

  task automatic rstep(input logic nb);
    logic fr;
    @(negedge aclk);
    s_tvalid     = ($urandom_range(0, 3) != 0);
    s_tdata      = $urandom;
    cfg_mode     = 2'($urandom_range(0, 3));
    m_tready     = 2'($urandom);
    cfg_chan_en  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
    cfg_nonblock = nb;
    #1;
    fr = !((q0.size() != 0 && !m_tready[0]) ||
           (q1.size() != 0 && !m_tready[1]));
    chk("rnd_tready", 64'(s_tready),
        64'(nb || fr || cfg_chan_en == 2'b00));
    chk("rnd_tvalid0", 64'(m_tvalid[0]), 64'(q0.size() != 0));
    chk("rnd_tvalid1", 64'(m_tvalid[1]), 64'(q1.size() != 0));
    if (q0.size() != 0) begin
      chk("rnd_data0", 64'(m_tdata[31:0]), 64'(q0[0]));
      if (m_tready[0]) void'(q0.pop_front());
    end
    if (q1.size() != 0) begin
      chk("rnd_data1", 64'(m_tdata[63:32]), 64'(q1[0]));
      if (m_tready[1]) void'(q1.pop_front());
    end
    if (nb) chk("rnd_drops", 64'(sts_drop_count), 64'(mcnt));
    if (s_tvalid && fr) begin
      if (cfg_chan_en[0]) q0.push_back(ref_conv(cfg_mode, s_tdata[15:0]));
      if (cfg_chan_en[1]) q1.push_back(ref_conv(cfg_mode, s_tdata[31:16]));
      if (cfg_chan_en != 2'b00) beats++;
    end else if (nb && s_tvalid && !fr && cfg_chan_en != 2'b00) begin
      if (mcnt < 64'hFFFF_FFFF) mcnt++;
    end
  endtask

  task automatic idle();
    @(negedge aclk);
    s_tvalid = 1'b0;
    m_tready = 2'b11;
    @(negedge aclk);
  endtask

  initial begin
    logic [31:0] d0;
    logic [31:0] d1;
    int budget;

    tbl[0] = '{2'd0, 16'h2000, 16'h1FFF, 32'hFFFFE000, 32'h00001FFF};
    tbl[1] = '{2'd0, 16'hE000, 16'hDFFF, 32'hFFFFE000, 32'h00001FFF};
    tbl[2] = '{2'd1, 16'h2000, 16'h0001, 32'h00002000, 32'h00000001};
    tbl[3] = '{2'd2, 16'h2000, 16'h0000, 32'h00000000, 32'hFFFFE000};
    tbl[4] = '{2'd3, 16'h2000, 16'h0001, 32'h00001FFF, 32'hFFFFFFFF};
    tbl[5] = '{2'd3, 16'h1FFF, 16'h0000, 32'hFFFFE001, 32'h00000000};
    tbl[6] = '{2'd2, 16'h3FFF, 16'h1FFF, 32'h00001FFF, 32'hFFFFFFFF};

    aresetn      = 1'b0;
    s_tdata      = '0;
    s_tvalid     = 1'b0;
    m_tready     = 2'b11;
    cfg_mode     = 2'd0;
    cfg_chan_en  = 2'b11;
    cfg_nonblock = 1'b0;
    cfg_drop_clr = 1'b0;

    @(negedge aclk);
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'(2'b00));
    chk("rst_tdata", m_tdata, 64'h0);
    chk("rst_drops", 64'(sts_drop_count), 64'h0);
    chk("rst_tready", 64'(s_tready), 64'h1);
    @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge aclk);
      cfg_mode = tbl[i].mode;
      s_tdata  = {tbl[i].l1, tbl[i].l0};
      s_tvalid = 1'b1;
      #1;
      chk("tbl_tready", 64'(s_tready), 64'h1);
      @(negedge aclk);
      s_tvalid = 1'b0;
      #1;
      chk("tbl_tvalid", 64'(m_tvalid), 64'(2'b11));
      chk("tbl_ch0", 64'(m_tdata[31:0]), 64'(tbl[i].e0));
      chk("tbl_ch1", 64'(m_tdata[63:32]), 64'(tbl[i].e1));
    end
    idle();

    budget = 0;
    while (beats < 100 && budget < 3000) begin
      rstep(1'b0);
      budget++;
    end
    chk("rnd_beats", 64'(beats >= 100), 64'h1);
    for (int i = 0; i < 200; i++) rstep(1'b1);
    @(negedge aclk);
    s_tvalid     = 1'b0;
    m_tready     = 2'b11;
    cfg_drop_clr = 1'b1;
    @(negedge aclk);
    cfg_drop_clr = 1'b0;
    cfg_nonblock = 1'b0;
    cfg_chan_en  = 2'b11;
    cfg_mode     = 2'd0;
    q0.delete();
    q1.delete();
    #1;
    chk("drain_tvalid", 64'(m_tvalid), 64'h0);

    d0 = 32'h1234_0567;
    d1 = 32'h0ABC_3DEF;
    s_tdata  = d0;
    s_tvalid = 1'b1;
    @(negedge aclk);
    m_tready = 2'b01;
    s_tdata  = d1;
    #1;
    chk("stall_tvalid", 64'(m_tvalid), 64'(2'b11));
    chk("stall_tready", 64'(s_tready), 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      #1;
      chk("stall_tready", 64'(s_tready), 64'h0);
      chk("stall_tvalid", 64'(m_tvalid), 64'(2'b10));
      chk("stall_ch0", 64'(m_tdata[31:0]), 64'(ref_conv(2'd0, d0[15:0])));
      chk("stall_ch1", 64'(m_tdata[63:32]), 64'(ref_conv(2'd0, d0[31:16])));
    end
    @(negedge aclk);
    m_tready = 2'b11;
    #1;
    chk("resume_tready", 64'(s_tready), 64'h1);
    @(negedge aclk);
    s_tvalid = 1'b0;
    #1;
    chk("resume_ch0", 64'(m_tdata[31:0]), 64'(ref_conv(2'd0, d1[15:0])));
    chk("resume_ch1", 64'(m_tdata[63:32]), 64'(ref_conv(2'd0, d1[31:16])));
    idle();

    cfg_nonblock = 1'b1;
    s_tvalid     = 1'b1;
    m_tready     = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      @(negedge aclk);
      #1;
      chk("nb_tready", 64'(s_tready), 64'h1);
      chk("nb_drops", 64'(sts_drop_count), 64'(k - 1));
    end
    @(negedge aclk);
    #1;
    chk("nb_drops10", 64'(sts_drop_count), 64'd10);
    cfg_drop_clr = 1'b1;
    @(negedge aclk);
    cfg_drop_clr = 1'b0;
    #1;
    chk("nb_clr", 64'(sts_drop_count), 64'h0);
    s_tvalid = 1'b0;
    idle();

    cfg_nonblock = 1'b0;
    cfg_chan_en  = 2'b01;
    m_tready     = 2'b01;
    s_tvalid     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      #1;
      chk("en01_tvalid", 64'(m_tvalid), 64'(2'b01));
      chk("en01_tready", 64'(s_tready), 64'h1);
    end
    m_tready     = 2'b00;
    @(negedge aclk);
    cfg_chan_en  = 2'b00;
    cfg_nonblock = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      #1;
      chk("en00_tready", 64'(s_tready), 64'h1);
      chk("en00_hold", 64'(m_tvalid), 64'(2'b01));
      chk("en00_drops", 64'(sts_drop_count), 64'h0);
    end
    m_tready = 2'b11;
    @(negedge aclk);
    #1;
    chk("en00_none", 64'(m_tvalid), 64'h0);
    s_tvalid = 1'b0;
    idle();

    cfg_chan_en = 2'b11;
    s_tvalid    = 1'b1;
    m_tready    = 2'b00;
    repeat (3) @(negedge aclk);
    #1;
    chk("pre_rst_drops", 64'(sts_drop_count), 64'd2);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_tvalid", 64'(m_tvalid), 64'h0);
    chk("arst_drops", 64'(sts_drop_count), 64'h0);
    @(negedge aclk);
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    @(negedge aclk);
    #1;
    chk("post_rst_idle", 64'(m_tvalid), 64'h0);
    s_tdata  = 32'h0003_0002;
    s_tvalid = 1'b1;
    m_tready = 2'b11;
    #1;
    chk("lat_before", 64'(m_tvalid), 64'h0);
    @(posedge aclk);
    #1;
    chk("lat_after", 64'(m_tvalid), 64'(2'b11));
    chk("lat_data", m_tdata, 64'h0000_0003_0000_0002);

    @(negedge aclk);
    m_tready = 2'b00;
    force dut.drop_q = 32'hFFFF_FFFE;
    @(posedge aclk);
    #1;
    release dut.drop_q;
    for (int k = 0; k < 2; k++) begin
      @(posedge aclk);
      #1;
      chk("sat_drops", 64'(sts_drop_count), 64'hFFFF_FFFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
